// File: rtl/harq_send_scheduler_if.sv
// HARQ write-path beat stream: saturated LLR beats
// with valid/ready handshake and end-of-block marker.
interface harq_send_scheduler_if #(
  parameter int LLR_NUM = 16,
  parameter int OUT_W   = 8
);
  logic [LLR_NUM*OUT_W-1:0] data;
  logic                     valid;
  logic                     ready;
  logic                     last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/harq_send_scheduler.sv
// Streams a ping/pong combined-LLR buffer to the HARQ
// write path as saturated beats, then pulses completion.
module harq_send_scheduler #(
  parameter int ADDR_WIDTH = 11,
  parameter int LLR_NUM    = 16,
  parameter int IN_W       = 10,
  parameter int OUT_W      = 8
) (
  input  logic                    i_core_clk,
  input  logic                    i_rx_rst,
  input  logic                    i_SENDHARQ_Data_request,
  input  logic                    i_SENDHARQ_Data_PingPong_Indicator,
  input  logic [15:0]             i_SENDHARQ_Data_ncb,
  output logic [ADDR_WIDTH-1:0]   o_SENDHARQ_Data_Address,
  input  logic [LLR_NUM*IN_W-1:0] i_Ping_Buffer_Read_Data,
  input  logic [LLR_NUM*IN_W-1:0] i_Pong_Buffer_Read_Data,
  harq_send_scheduler_if.master   o_harq,
  output logic                    o_SENDHARQ_Data_Comp,
  output logic                    o_busy
);

  localparam int DW   = LLR_NUM * OUT_W;
  localparam int AMAX = (2 ** ADDR_WIDTH) - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_pp;
  logic [ADDR_WIDTH-1:0] r_nm1;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_infl;
  logic                  r_infl_last;
  logic [DW-1:0]         r_hd;
  logic [DW-1:0]         r_td;
  logic                  r_hv;
  logic                  r_tv;
  logic                  r_hl;
  logic                  r_tl;

  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_last_issue;
  logic [11:0]           w_blk;
  logic [ADDR_WIDTH-1:0] w_nm1;
  logic [DW-1:0]         w_pd;

  function automatic logic [DW-1:0] sat(
    input logic [LLR_NUM*IN_W-1:0] d
  );
    logic [DW-1:0]        r;
    logic [IN_W-1:0]      x;
    logic [IN_W-OUT_W:0]  hi;
    r = '0;
    for (int i = 0; i < LLR_NUM; i++) begin
      x  = d[i*IN_W +: IN_W];
      hi = x[IN_W-1:OUT_W-1];
      // in range when all bits above the byte match its sign
      if ((&hi) || !(|hi))
        r[i*OUT_W +: OUT_W] = x[OUT_W-1:0];
      else if (x[IN_W-1])
        r[i*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
      else
        r[i*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return r;
  endfunction

  assign w_pop = r_hv & o_harq.ready;
  assign w_occ = 3'(r_hv) + 3'(r_tv)
               + 3'(r_infl) - 3'(w_pop);
  assign w_issue = (r_state == S_READ) && (w_occ < 3'd2);
  assign w_last_issue = w_issue && (r_addr == r_nm1);

  assign w_blk = i_SENDHARQ_Data_ncb[15:4];
  assign w_nm1 = (32'(w_blk) > AMAX)
               ? ADDR_WIDTH'(AMAX)
               : ADDR_WIDTH'(w_blk);

  assign w_pd = sat(r_pp ? i_Ping_Buffer_Read_Data
                         : i_Pong_Buffer_Read_Data);

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_SENDHARQ_Data_request) w_next = S_READ;
      S_READ:  if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_occ == 3'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy               = (r_state != S_IDLE);
    o_SENDHARQ_Data_Comp = (r_state == S_DONE);
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      r_pp        <= 1'b0;
      r_nm1       <= '0;
      r_addr      <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_SENDHARQ_Data_request) begin
        r_pp   <= i_SENDHARQ_Data_PingPong_Indicator;
        r_nm1  <= w_nm1;
        r_addr <= '0;
      end
      if (w_issue) r_addr <= r_addr + ADDR_WIDTH'(1);
      if (r_state == S_DONE) r_addr <= '0;
      r_infl      <= w_issue;
      r_infl_last <= w_last_issue;
    end
  end

  // 2-entry FIFO; the head entry is the output register
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      r_hd <= '0;
      r_td <= '0;
      r_hv <= 1'b0;
      r_tv <= 1'b0;
      r_hl <= 1'b0;
      r_tl <= 1'b0;
    end else if (w_pop) begin
      if (r_tv) begin
        r_hd <= r_td;
        r_hl <= r_tl;
        r_tv <= r_infl;
        if (r_infl) begin
          r_td <= w_pd;
          r_tl <= r_infl_last;
        end
      end else begin
        r_hv <= r_infl;
        if (r_infl) begin
          r_hd <= w_pd;
          r_hl <= r_infl_last;
        end
      end
    end else if (r_infl) begin
      if (r_hv) begin
        r_td <= w_pd;
        r_tl <= r_infl_last;
        r_tv <= 1'b1;
      end else begin
        r_hd <= w_pd;
        r_hl <= r_infl_last;
        r_hv <= 1'b1;
      end
    end
  end

  assign o_harq.data  = r_hd;
  assign o_harq.valid = r_hv;
  assign o_harq.last  = r_hl;

  assign o_SENDHARQ_Data_Address = r_addr;

endmodule

// File: tb/tb_harq_send_scheduler.sv
// Bench for harq_send_scheduler: SRAM models, directed
// scenarios with random data/ready, reference queue.
module tb_harq_send_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic         pp = 1'b0;
  logic [15:0]  ncb_i = '0;
  logic [10:0]  addr;
  logic [159:0] ping_q = '0;
  logic [159:0] pong_q = '0;
  logic         comp;
  logic         busy;

  logic [159:0] ping [2048];
  logic [159:0] pong [2048];
  logic [127:0] last_data;

  int checks = 0;
  int errors = 0;

  harq_send_scheduler_if hif ();

  harq_send_scheduler dut (
    .i_core_clk                         (clk),
    .i_rx_rst                           (rst),
    .i_SENDHARQ_Data_request            (req),
    .i_SENDHARQ_Data_PingPong_Indicator (pp),
    .i_SENDHARQ_Data_ncb                (ncb_i),
    .o_SENDHARQ_Data_Address            (addr),
    .i_Ping_Buffer_Read_Data            (ping_q),
    .i_Pong_Buffer_Read_Data            (pong_q),
    .o_harq                             (hif),
    .o_SENDHARQ_Data_Comp               (comp),
    .o_busy                             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ping_q <= ping[addr];
    pong_q <= pong[addr];
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_word(
    input logic [159:0] w
  );
    logic [127:0] r;
    logic [9:0]   f;
    int x;
    int y;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      f = w[10*i +: 10];
      x = int'(signed'(f));
      if (x > 127)       y = 127;
      else if (x < -128) y = -128;
      else               y = x;
      r[8*i +: 8] = 8'(y);
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 2048; k++) begin
      for (int i = 0; i < 5; i++) begin
        ping[k][32*i +: 32] = $urandom;
        pong[k][32*i +: 32] = $urandom;
      end
    end
  endtask

  task automatic idle_checks(input string tag);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_comp"}, 128'(comp), 128'(0));
    end
    chk({tag, "_addr"}, 128'(addr), 128'(0));
  endtask

  task automatic run_block(input bit ind,
                           input logic [15:0] ncb,
                           input int rmode,
                           input int abort_at,
                           input bit busy_req);
    logic [127:0] exp_q[$];
    logic [127:0] held;
    int n, c, got, first, acc_c, lim;
    bit stalled, done;
    n = ((ncb >> 4) > 2047) ? 2048 : int'(ncb >> 4) + 1;
    for (int k = 0; k < n; k++)
      exp_q.push_back(ref_word(ind ? ping[k] : pong[k]));
    got = 0; first = -1; acc_c = -10;
    stalled = 0; done = 0; held = '0;
    lim = 4 * n + 40;
    @(negedge clk);
    req = 1'b1; pp = ind; ncb_i = ncb;
    @(negedge clk);
    req = 1'b0; pp = ~ind; ncb_i = 16'($urandom);
    c = 1;
    while (!done && c < lim) begin
      case (rmode)
        0:       hif.ready = 1'b1;
        1:       hif.ready = ((c-1) % 4 == 0) || ((c-1) % 4 == 3);
        default: hif.ready = ($urandom_range(0, 3) != 0);
      endcase
      if (busy_req) begin
        req = (c == 5);
        if (c == 5) ncb_i = 16'd32;
      end
      #1;
      if (c == 1) begin
        chk("addr_c1", 128'(addr), 128'(0));
        chk("busy_c1", 128'(busy), 128'(1));
      end
      if (hif.valid && first < 0) first = c;
      if (stalled) chk("stall_stable", hif.data, held);
      if (comp) begin
        chk("comp_after_last", 128'(c), 128'(acc_c + 1));
        chk("comp_beats", 128'(got), 128'(n));
        done = 1;
      end
      if (hif.valid && hif.ready) begin
        chk("beat_in_range", 128'(got < n), 128'(1));
        if (got < n) begin
          chk("beat_data", hif.data, exp_q[got]);
          chk("beat_last", 128'(hif.last),
              128'(got == n - 1));
        end
        last_data = hif.data;
        got++;
        acc_c = c;
      end
      stalled = hif.valid && !hif.ready;
      held = hif.data;
      if (abort_at > 0 && got == abort_at) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_addr", 128'(addr), 128'(0));
        chk("rst_data", hif.data, 128'(0));
        chk("rst_valid", 128'(hif.valid), 128'(0));
        chk("rst_last", 128'(hif.last), 128'(0));
        chk("rst_comp", 128'(comp), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        idle_checks("abort");
        return;
      end
      @(negedge clk);
      c++;
    end
    req = 1'b0;
    chk("no_timeout", 128'(done), 128'(1));
    chk("first_valid_cycle", 128'(first), 128'(3));
    chk("beat_count", 128'(got), 128'(n));
    idle_checks("post");
  endtask

  initial begin
    int v[8];
    hif.ready = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_addr", 128'(addr), 128'(0));
    chk("reset_data", hif.data, 128'(0));
    chk("reset_valid", 128'(hif.valid), 128'(0));
    chk("reset_last", 128'(hif.last), 128'(0));
    chk("reset_comp", 128'(comp), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    rst = 1'b0;

    for (int k = 0; k < 11; k++)
      for (int i = 0; i < 16; i++)
        pong[k][10*i +: 10] = 10'(k);
    run_block(1'b0, 16'd160, 0, 0, 1'b0);
    chk("basic_last_word", last_data, {16{8'd10}});

    v = '{511, -512, 127, -128, 128, -129, 0, -1};
    ping[0] = '0;
    for (int i = 0; i < 8; i++)
      ping[0][10*i +: 10] = 10'(v[i]);
    run_block(1'b1, 16'd0, 0, 0, 1'b0);
    chk("sat_lo", last_data[63:0],
        128'(64'hFF00_807F_807F_807F));
    chk("sat_hi", last_data[127:64], 128'(0));

    fill_random();
    run_block(1'b0, 16'd320, 1, 0, 1'b0);
    run_block(1'b1, 16'd160, 0, 0, 1'b1);
    run_block(1'b0, 16'd160, 0, 4, 1'b0);
    run_block(1'b1, 16'($urandom_range(0, 511)), 2, 0, 1'b0);
    run_block(1'b1, 16'd15, 2, 0, 1'b0);
    run_block(1'b0, 16'hFFFF, 2, 0, 1'b0);
    chk("clamp_last_word", last_data, ref_word(pong[2047]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/harq_send_scheduler.md
Name: harq_send_scheduler

Overview:
Downstream consumer of the combine stage's ping/pong combined-LLR buffers. On a send request it reads ncb[15:4]+1 words of 16x10-bit combined LLRs from the selected buffer, using the SRAM's 1-cycle read latency. It saturates each LLR to 8 bits and streams 128-bit beats to the HARQ write path with valid/ready backpressure. After the last beat it pulses o_SENDHARQ_Data_Comp, which releases the combine stage from WAIT.

Parameters:
ADDR_WIDTH, 11, buffer address width; maximum word index 2^ADDR_WIDTH-1
LLR_NUM, 16, LLRs per buffer word
IN_W, 10, signed combined-LLR width
OUT_W, 8, signed output-LLR width after saturation

Ports:
i_core_clk  in  1  core clock, all logic rising-edge
i_rx_rst  in  1  synchronous active-high reset
i_SENDHARQ_Data_request  in  1  start request; sampled only in IDLE
i_SENDHARQ_Data_PingPong_Indicator  in  1  latched at accept; 0 selects Pong read data, 1 selects Ping read data
i_SENDHARQ_Data_ncb  in  16  latched at accept; word count = ncb[15:4]+1
o_SENDHARQ_Data_Address  out  ADDR_WIDTH  read address driven to the selected buffer
i_Ping_Buffer_Read_Data  in  LLR_NUM*IN_W  Ping SRAM q, registered, 1-cycle latency
i_Pong_Buffer_Read_Data  in  LLR_NUM*IN_W  Pong SRAM q, registered, 1-cycle latency
o_harq_data  out  LLR_NUM*OUT_W  saturated LLR beat; LLR i at [8i+7:8i] comes from input [10i+9:10i]
o_harq_valid  out  1  beat valid
i_harq_ready  in  1  downstream accepts when valid&ready
o_harq_last  out  1  qualifies the final beat of the block
o_SENDHARQ_Data_Comp  out  1  one-cycle completion pulse
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, i_rx_rst=1 at a clock edge): state IDLE. All outputs are 0: o_SENDHARQ_Data_Address, o_harq_data, o_harq_valid, o_harq_last, o_SENDHARQ_Data_Comp, o_busy. FIFO is emptied and in-flight flags are cleared.
- Reset mid-operation aborts the transfer immediately. No Comp pulse is produced and the partial block is discarded.
- States:
  - IDLE: on request=1, latch indicator and ncb, compute N = min(ncb[15:4], 2^ADDR_WIDTH-1)+1, clear word counter, go to READ.
  - READ: issue reads to addresses 0..N-1 in order. After the issue of address N-1, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
  - DONE: o_SENDHARQ_Data_Comp=1 for exactly one cycle, then IDLE.
- Read issue: a read is issued in a cycle when state is READ and (fifo_count + inflight - pop) < 2, where pop = o_harq_valid & i_harq_ready.
  - Address advances by 1 only on issue; otherwise it holds.
  - Data for an address presented in cycle t is sampled from the SRAM q in cycle t+1 and written into a 2-entry FIFO at the end of t+1.
  - Only genuine issues are captured; the q of non-issue cycles is ignored.
- Output: o_harq_data, o_harq_valid and o_harq_last come from the FIFO head, registered.
  - Data is stable while valid=1 and ready=0.
  - With ready held high, throughput is 1 beat/cycle.
  - Latency is fixed: request accepted in cycle 0 gives address 0 in cycle 1 and first o_harq_valid in cycle 3.
- Saturation: each signed 10-bit LLR x maps to 127 if x>127, to -128 if x<-128, otherwise to x[7:0].
- o_harq_last=1 only on the beat carrying word N-1.
- Request handling: a request while busy is ignored, and latched parameters are not altered. A request in the same cycle as the DONE pulse is ignored; it is accepted from the following IDLE cycle.
- ncb boundaries: ncb < 16 gives N=1, a single beat that is both first and last. ncb[15:4] > 2047 is clamped to N = 2048.
- Ping/pong selection is fixed for the whole block from the latched indicator. Input indicator changes during operation have no effect.
- o_SENDHARQ_Data_Address returns to 0 on entry to IDLE.

Test Plan:
- Basic: ncb=160, indicator=0, ready=1. Pong word k holds all LLRs equal to k. Response: 11 beats on consecutive cycles from cycle 3; beat k has every byte = k; last on beat 10; Comp pulses one cycle after beat 10.
- Saturation: Ping word 0 holds LLRs {+511, -512, +127, -128, +128, -129, 0, -1, ...}, indicator=1, ncb=0. Response: one beat {127, -128, 127, -128, 127, -128, 0, -1}; last=1.
- Backpressure: ncb=320 (21 words), ready toggled 1,0,0,1 repeating. Response: every word delivered exactly once in order; data stable while stalled; FIFO never exceeds 2 entries; Comp only after word 20 is accepted.
- Request while busy: second request with ncb=32 asserted mid-transfer of ncb=160. Response: it is ignored; exactly 11 beats and one Comp.
- Reset mid-operation: i_rx_rst=1 after beat 4 of 11. Response: the next cycle shows all outputs 0 and state IDLE; no Comp; a fresh request then starts again from address 0.
- Clamp: ncb=16'hFFFF. Response: 2048 beats, addresses 0..2047, last on address 2047.
